// File: rtl/dds_chan_sched_if.sv
// Bus bundle for the DDS channel scheduler: config writes, evaluator loop and sample stream.
interface dds_chan_sched_if #(
  parameter int unsigned CHW = 2
);
  localparam int unsigned PW = 21;
  localparam int unsigned DW = 17;

  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [PW-1:0]  cfg_inc;
  logic           cfg_en;
  logic           cfg_clr;
  logic [PW-1:0]  phase_out;
  logic [DW-1:0]  sine_in;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [CHW-1:0] out_ch;

  modport master (
    output cfg_we, cfg_ch, cfg_inc, cfg_en, cfg_clr, sine_in, out_ready,
    input  phase_out, out_valid, out_data, out_ch
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_inc, cfg_en, cfg_clr, sine_in, out_ready,
    output phase_out, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/dds_chan_sched.sv
// Round-robin phase-accumulator scheduler sharing one sine evaluator across NCH channels.
module dds_chan_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 2
) (
  input  logic            clk,
  input  logic            rst,
  dds_chan_sched_if.slave bus
);
  localparam int unsigned PW = 21;
  localparam int unsigned DW = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CHW-1:0] slot_q, slot_d;
  logic [PW-1:0]  acc_q [NCH];
  logic [PW-1:0]  acc_d [NCH];
  logic [PW-1:0]  inc_q [NCH];
  logic [PW-1:0]  inc_d [NCH];
  logic [NCH-1:0] en_q, en_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic [CHW-1:0] out_ch_q, out_ch_d;
  logic           can_issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Channel enables after this cycle's write decide RUN vs IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|en_d) state_d = RUN;
      RUN: begin
        if (~|en_d)                              state_d = IDLE;
        else if (out_valid_q && !bus.out_ready)  state_d = HOLD;
      end
      HOLD: if (bus.out_ready) state_d = (|en_d) ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    can_issue   = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    slot_d      = slot_q;
    acc_d       = acc_q;
    inc_d       = inc_q;
    en_d        = en_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;

    if (can_issue) begin
      slot_d = (slot_q == CHW'(NCH - 1)) ? '0 : slot_q + CHW'(1);
      if (en_q[slot_q]) begin
        out_valid_d    = 1'b1;
        out_data_d     = bus.sine_in;
        out_ch_d       = slot_q;
        acc_d[slot_q]  = acc_q[slot_q] + inc_q[slot_q];
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Applied after the issue so a same-cycle clear wins over the increment.
    if (bus.cfg_we) begin
      inc_d[bus.cfg_ch] = bus.cfg_inc;
      en_d[bus.cfg_ch]  = bus.cfg_en;
      if (bus.cfg_clr) acc_d[bus.cfg_ch] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= '0;
      en_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= '0;
      end
    end else begin
      slot_q      <= slot_d;
      en_q        <= en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
    end
  end

  assign bus.phase_out = acc_q[slot_q];
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_dds_chan_sched.sv
// Directed bench for dds_chan_sched: vector table for steady-state issue plus stall/clear/reset/wrap sequences.
module tb_dds_chan_sched;
  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dds_chan_sched_if #(.CHW(CHW)) bus ();
  dds_chan_sched #(.NCH(NCH), .CHW(CHW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Stand-in evaluator: any distinct function of the phase will do.
  function automatic logic [16:0] sine_f(input logic [20:0] p);
    return p[16:0] ^ 17'h15A5A;
  endfunction

  assign bus.sine_in = sine_f(bus.phase_out);

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  ch;
    logic [20:0] inc;
    logic        en;
    logic        ev;
    logic [1:0]  ech;
    logic [20:0] dph;
    logic [20:0] ph;
    logic [1:0]  sl;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic r, input logic we, input logic [1:0] ch,
                              input logic [20:0] inc, input logic en, input logic ev,
                              input logic [1:0] ech, input logic [20:0] dph,
                              input logic [20:0] ph, input logic [1:0] sl);
    vec_t v;
    v.rst = r; v.we = we; v.ch = ch; v.inc = inc; v.en = en;
    v.ev = ev; v.ech = ech; v.dph = dph; v.ph = ph; v.sl = sl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] ch, input logic [20:0] inc,
                       input logic en, input logic clr);
    bus.cfg_we  = we;
    bus.cfg_ch  = ch;
    bus.cfg_inc = inc;
    bus.cfg_en  = en;
    bus.cfg_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 2'd0, 21'd0, 1'b0, 1'b0);

    // Scenario A: ch0 alone, inc 0x400, visited every NCH cycles.
    tbl[0]  = mk(1, 0, 0, 0,       0, 0, 0, 0,       0,       0);
    tbl[1]  = mk(0, 1, 0, 21'h400, 1, 0, 0, 0,       0,       0);
    tbl[2]  = mk(0, 0, 0, 0,       0, 1, 0, 0,       0,       1);
    tbl[3]  = mk(0, 0, 0, 0,       0, 0, 0, 0,       0,       2);
    tbl[4]  = mk(0, 0, 0, 0,       0, 0, 0, 0,       0,       3);
    tbl[5]  = mk(0, 0, 0, 0,       0, 0, 0, 0,       21'h400, 0);
    tbl[6]  = mk(0, 0, 0, 0,       0, 1, 0, 21'h400, 0,       1);
    tbl[7]  = mk(0, 0, 0, 0,       0, 0, 0, 0,       0,       2);
    tbl[8]  = mk(0, 0, 0, 0,       0, 0, 0, 0,       0,       3);
    tbl[9]  = mk(0, 0, 0, 0,       0, 0, 0, 0,       21'h800, 0);
    tbl[10] = mk(0, 0, 0, 0,       0, 1, 0, 21'h800, 0,       1);
    // Scenario B: all four channels, inc 1..4, one sample per cycle.
    tbl[11] = mk(1, 0, 0, 0,       0, 0, 0, 0,       0,       0);
    tbl[12] = mk(0, 1, 0, 21'd1,   1, 0, 0, 0,       0,       0);
    tbl[13] = mk(0, 1, 1, 21'd2,   1, 1, 0, 0,       0,       1);
    tbl[14] = mk(0, 1, 2, 21'd3,   1, 1, 1, 0,       0,       2);
    tbl[15] = mk(0, 1, 3, 21'd4,   1, 1, 2, 0,       0,       3);
    tbl[16] = mk(0, 0, 0, 0,       0, 1, 3, 0,       21'd1,   0);
    tbl[17] = mk(0, 0, 0, 0,       0, 1, 0, 21'd1,   21'd2,   1);
    tbl[18] = mk(0, 0, 0, 0,       0, 1, 1, 21'd2,   21'd3,   2);
    tbl[19] = mk(0, 0, 0, 0,       0, 1, 2, 21'd3,   21'd4,   3);
    tbl[20] = mk(0, 0, 0, 0,       0, 1, 3, 21'd4,   21'd2,   0);
    tbl[21] = mk(0, 0, 0, 0,       0, 1, 0, 21'd2,   21'd4,   1);

    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst;
      drive(tbl[i].we, tbl[i].ch, tbl[i].inc, tbl[i].en, 1'b0);
      tick();
      chk($sformatf("v%0d valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d phase", i), 32'(bus.phase_out), 32'(tbl[i].ph));
      chk($sformatf("v%0d slot", i),  32'(dut.slot_q),    32'(tbl[i].sl));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d ch", i),   32'(bus.out_ch),   32'(tbl[i].ech));
        chk($sformatf("v%0d data", i), 32'(bus.out_data), 32'(sine_f(tbl[i].dph)));
      end
    end

    // Stall 5 cycles with ch0 sample pending: everything frozen.
    drive(1'b0, 2'd0, 21'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold%0d valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("hold%0d ch", k),    32'(bus.out_ch),    32'd0);
      chk($sformatf("hold%0d data", k),  32'(bus.out_data),  32'(sine_f(21'd2)));
      chk($sformatf("hold%0d phase", k), 32'(bus.phase_out), 32'd4);
      chk($sformatf("hold%0d slot", k),  32'(dut.slot_q),    32'd1);
      chk($sformatf("hold%0d state", k), 32'(dut.state_q),   32'd2);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("release drain valid", 32'(bus.out_valid), 32'd0);
    chk("release state",       32'(dut.state_q),   32'd1);
    tick();
    chk("after hold ch",   32'(bus.out_ch),   32'd1);
    chk("after hold data", 32'(bus.out_data), 32'(sine_f(21'd4)));
    chk("after hold slot", 32'(dut.slot_q),   32'd2);

    // Clear ch2 in the cycle it issues: old phase out, accumulator zeroed.
    drive(1'b1, 2'd2, 21'd3, 1'b1, 1'b1);
    tick();
    chk("clr ch",    32'(bus.out_ch),   32'd2);
    chk("clr data",  32'(bus.out_data), 32'(sine_f(21'd6)));
    chk("clr acc2",  32'(dut.acc_q[2]), 32'd0);
    drive(1'b0, 2'd0, 21'd0, 1'b0, 1'b0);

    // Reset while stalled in HOLD.
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("pre-rst state", 32'(dut.state_q),   32'd2);
    chk("pre-rst valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst valid", 32'(bus.out_valid), 32'd0);
    chk("rst state", 32'(dut.state_q),   32'd0);
    chk("rst phase", 32'(bus.phase_out), 32'd0);
    for (int c = 0; c < 4; c++) chk($sformatf("rst acc%0d", c), 32'(dut.acc_q[c]), 32'd0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post-rst%0d valid", k), 32'(bus.out_valid), 32'd0);
      chk($sformatf("post-rst%0d state", k), 32'(dut.state_q),   32'd0);
    end

    // ch1 wrap: inc rewritten during its own issue takes effect next visit.
    drive(1'b1, 2'd1, 21'd1, 1'b1, 1'b0);
    tick();
    chk("wrap en state", 32'(dut.state_q), 32'd1);
    drive(1'b0, 2'd0, 21'd0, 1'b0, 1'b0);
    tick();
    chk("wrap skip0 valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 2'd1, 21'h1FFFFF, 1'b1, 1'b0);
    tick();
    chk("wrap issue1 ch",   32'(bus.out_ch),   32'd1);
    chk("wrap issue1 data", 32'(bus.out_data), 32'(sine_f(21'd0)));
    chk("wrap acc1 old inc", 32'(dut.acc_q[1]), 32'd1);
    drive(1'b0, 2'd0, 21'd0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("wrap phase", 32'(bus.phase_out), 32'd1);
    tick();
    chk("wrap issue2 valid", 32'(bus.out_valid), 32'd1);
    chk("wrap issue2 data",  32'(bus.out_data),  32'(sine_f(21'd1)));
    chk("wrap acc1 zero",    32'(dut.acc_q[1]),  32'd0);

    // Disable ch1 while its sample is stalled: sample survives, then drains in IDLE.
    drive(1'b1, 2'd1, 21'h1FFFFF, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    tick();
    chk("dis valid", 32'(bus.out_valid), 32'd1);
    chk("dis ch",    32'(bus.out_ch),    32'd1);
    chk("dis data",  32'(bus.out_data),  32'(sine_f(21'd1)));
    chk("dis state", 32'(dut.state_q),   32'd0);
    drive(1'b0, 2'd0, 21'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk("drain valid", 32'(bus.out_valid), 32'd0);
    chk("drain state", 32'(dut.state_q),   32'd0);
    tick();
    chk("idle valid", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dds_chan_sched.md
DDS_CHAN_SCHED -- requirements
Module: dds_chan_sched

Interface
REQ-001 Parameter NCH, default 4, number of phase channels; legal values 2, 4 and 8.
REQ-002 Parameter CHW, default 2, channel index width; SHALL equal log2(NCH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cfg_we  input  1  config write strobe, one cycle per write.
REQ-006 cfg_ch  input  CHW  channel addressed by the write.
REQ-007 cfg_inc  input  21  phase increment for the addressed channel.
REQ-008 cfg_en  input  1  enable for the addressed channel.
REQ-009 cfg_clr  input  1  on a write, zero the addressed channel's accumulator.
REQ-010 phase_out  output  21  phase presented to the shared combinational sine evaluator.
REQ-011 sine_in  input  17  evaluator result for phase_out, same cycle.
REQ-012 out_valid  output  1  sample available.
REQ-013 out_ready  input  1  downstream accepts sample.
REQ-014 out_data  output  17  registered sample.
REQ-015 out_ch  output  CHW  channel that produced out_data.

Function
REQ-016 Per channel, hold inc[ch] (21 b), en[ch] (1 b) and acc[ch] (21 b); accumulation is modulo 2^21, carry discarded.
REQ-017 Round-robin slot counter 0..NCH-1; wraps from NCH-1 to 0.
REQ-018 phase_out SHALL equal acc[slot] at all times, including during stall.
REQ-019 can_issue = (state==RUN) && (!out_valid || out_ready).
REQ-020 On can_issue with en[slot]=1: out_data<=sine_in, out_ch<=slot, out_valid<=1, acc[slot]<=acc[slot]+inc[slot], slot advances.
REQ-021 On can_issue with en[slot]=0: no sample, acc unchanged, slot advances; out_valid<=0 if the current sample was accepted.
REQ-022 out_valid with out_ready=0: out_data, out_ch, out_valid, slot and all accumulators frozen.
REQ-023 Sample latency: one cycle from issue to out_valid; sustained throughput one sample per cycle when out_ready=1.
REQ-024 States: IDLE (all en=0), RUN, HOLD (out_valid=1 and out_ready=0).
REQ-025 IDLE -> RUN when any en becomes 1; slot resumes from its held value.
REQ-026 RUN -> HOLD when a sample is pending and out_ready=0; HOLD -> RUN on out_ready=1.
REQ-027 RUN -> IDLE when all en=0 after the write; a pending sample still drains via the handshake.
REQ-028 cfg write takes effect at the next edge; it is accepted in every state, including HOLD.
REQ-029 A write to the slot being issued in the same cycle: the issue uses the old inc and en; new values apply from the next visit.
REQ-030 cfg_clr with a same-cycle issue on that channel: the clear wins and acc becomes 0; the issued sample uses the pre-clear phase.
REQ-031 A cfg write that sets en=0 does not cancel a sample already in out_data.

Reset
REQ-032 rst=1 asynchronously sets state=IDLE, slot=0, all acc=0, inc=0, en=0, out_valid=0, out_data=0, out_ch=0; phase_out then reads 0.
REQ-033 rst asserted mid-HOLD discards the pending sample; there is no output until channels are re-enabled after release.

Verification
REQ-034 Enable ch0 only with inc=0x000400 and out_ready=1 -> ch0 issues every NCH cycles; phase_out for ch0 reads 0, 0x400, 0x800 on successive visits; out_ch=0.
REQ-035 All 4 channels enabled, inc = 1, 2, 3, 4, out_ready=1 -> out_ch sequence 0,1,2,3,0 back-to-back, one sample per cycle.
REQ-036 ch1 inc=0x1FFFFF, acc=0x000001 -> the next acc is 0x000000 (wrap with no carry).
REQ-037 Hold out_ready=0 for 5 cycles -> out_data, out_ch, phase_out and slot stay constant; after release, the next channel is issued exactly once.
REQ-038 Same-cycle cfg_clr and issue on ch2 -> the sample uses the old phase; acc[2]=0 afterwards.
REQ-039 Assert rst during HOLD -> out_valid=0 immediately; state=IDLE; all acc=0.
